// File: rtl/wrapper_source_if.sv
// ============================================================================
// Module  : wrapper_source_if
// Brief   : Command, status and word-stream signals of the wrapper_source
//           stream producer, with master (producer) and slave views.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wrapper_source_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] step;
    logic [LEN_W-1:0]  length;
    logic              buffer_full;
    logic              data_1_en;
    logic [DATA_W-1:0] data_1;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  sent_count;

    modport master (
        input  start, abort, mode, seed, step, length, buffer_full,
        output data_1_en, data_1, busy, done, sent_count
    );

    modport slave (
        output start, abort, mode, seed, step, length, buffer_full,
        input  data_1_en, data_1, busy, done, sent_count
    );
endinterface

`default_nettype wire

// File: rtl/wrapper_source.sv
// ============================================================================
// Module  : wrapper_source
// Brief   : Burst word generator (incrementing / constant / LFSR) feeding the
//           write side of the dual-clock word buffer, with full backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wrapper_source #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  wire logic         clk_1,
    input  wire logic         rst,
    wrapper_source_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]        c_mode_inc  = 2'b00;
    localparam logic [1:0]        c_mode_lfsr = 2'b10;
    localparam logic [DATA_W-1:0] c_lfsr_seed = DATA_W'(16'hACE1);

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_step;
    logic [LEN_W-1:0]  r_length;
    logic [DATA_W-1:0] r_data;
    logic              r_en;
    logic              r_busy;
    logic              r_done;
    logic [LEN_W-1:0]  r_count;

    logic              w_accept;
    logic [LEN_W-1:0]  w_count_inc;
    logic              w_last;
    logic              w_lfsr_fb;
    logic [DATA_W-1:0] w_next_word;
    logic [DATA_W-1:0] w_seed_word;

    assign w_accept    = r_en & ~bus.buffer_full;
    assign w_count_inc = r_count + 1'b1;
    assign w_last      = (w_count_inc == r_length);

    // Taps x^16+x^14+x^13+x^11+1 expressed relative to the MSB
    assign w_lfsr_fb = r_data[DATA_W-1] ^ r_data[DATA_W-3]
                     ^ r_data[DATA_W-4] ^ r_data[DATA_W-6];

    always_comb begin
        w_next_word = r_data;
        case (r_mode)
            c_mode_inc:  w_next_word = r_data + r_step;
            c_mode_lfsr: w_next_word = {r_data[DATA_W-2:0], w_lfsr_fb};
            default:     w_next_word = r_data;
        endcase
    end

    // An all-zero LFSR state would lock up, so a zero seed is replaced
    always_comb begin
        w_seed_word = bus.seed;
        if ((bus.mode == c_mode_lfsr) && (bus.seed == '0)) begin
            w_seed_word = c_lfsr_seed;
        end
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= '0;
            r_step   <= '0;
            r_length <= '0;
            r_data   <= '0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mode   <= bus.mode;
                        r_step   <= bus.step;
                        r_length <= bus.length;
                        r_data   <= w_seed_word;
                        r_count  <= '0;
                        if (bus.length != '0) begin
                            r_state <= ST_RUN;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        r_count <= w_count_inc;
                    end
                    // The final word stays on data_1 after the burst ends
                    if ((w_accept && w_last) || bus.abort) begin
                        r_state <= ST_DONE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_accept) begin
                        r_data <= w_next_word;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_1_en  = r_en;
    assign bus.data_1     = r_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sent_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_wrapper_source.sv
// ============================================================================
// Module  : tb_wrapper_source
// Brief   : Self-checking bench for wrapper_source against a word-sequence model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrapper_source;

    localparam int DW = 16;
    localparam int LW = 8;

    logic clk_1 = 1'b0;
    logic rst   = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_1 = ~clk_1;

    wrapper_source_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

    wrapper_source #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] w);
        return {w[14:0], ^(w & 16'hB400)};
    endfunction

    // Word k of a burst, computed directly from the burst parameters
    function automatic logic [15:0] expected_word(input logic [1:0] m, input logic [15:0] s,
                                                  input logic [15:0] st, input int k);
        logic [15:0] w;
        case (m)
            2'b00: return s + 16'(k) * st;
            2'b10: begin
                w = (s == 16'h0000) ? 16'hACE1 : s;
                for (int i = 0; i < k; i++) w = lfsr_step(w);
                return w;
            end
            default: return s;
        endcase
    endfunction

    task automatic check_idle_after(input string name, input logic [LW-1:0] cnt);
        tick();
        check({name, "_done_low"}, bus.done, 1'b0);
        check({name, "_idle_en"}, bus.data_1_en, 1'b0);
        check({name, "_idle_busy"}, bus.busy, 1'b0);
        check({name, "_idle_cnt"}, bus.sent_count, cnt);
    endtask

    // Starts a burst and follows it to the DONE cycle; returns there
    task automatic run_burst(input string name, input logic [1:0] m, input logic [15:0] s,
                             input logic [15:0] st, input int len, input int bp_pct,
                             input int abort_at, input int stall_at, input int stall_len,
                             output int accepted);
        int idx;
        int cycles;
        int stalled;
        logic bp;
        logic ab;
        idx = 0; cycles = 0; stalled = 0;
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.seed   = s;
        bus.step   = st;
        bus.length = LW'(len);
        tick();
        bus.start  = 1'b0;
        bus.mode   = 2'($urandom);
        bus.seed   = 16'($urandom);
        bus.step   = 16'($urandom);
        bus.length = LW'($urandom);
        if (len != 0) begin
            forever begin
                check({name, "_en"}, bus.data_1_en, 1'b1);
                check({name, "_busy"}, bus.busy, 1'b1);
                check({name, "_done_early"}, bus.done, 1'b0);
                check({name, "_cnt"}, bus.sent_count, LW'(idx));
                check({name, "_data"}, bus.data_1, expected_word(m, s, st, idx));
                if (idx == stall_at && stalled < stall_len) begin
                    bp = 1'b1;
                    stalled++;
                end else begin
                    bp = ($urandom_range(99) < bp_pct);
                end
                ab = (abort_at >= 0) && (idx == abort_at);
                bus.buffer_full = bp;
                bus.abort       = ab;
                tick();
                cycles++;
                if (!bp) idx++;
                if (ab || idx == len) break;
                if (cycles > 8 * len + 64) begin
                    check({name, "_timeout"}, 32'(cycles), 32'(len));
                    break;
                end
            end
        end
        bus.buffer_full = 1'b0;
        bus.abort       = 1'b0;
        check({name, "_end_en"}, bus.data_1_en, 1'b0);
        check({name, "_end_busy"}, bus.busy, 1'b0);
        check({name, "_end_done"}, bus.done, 1'b1);
        check({name, "_end_cnt"}, bus.sent_count, LW'(idx));
        accepted = idx;
    endtask

    initial begin
        int acc;
        int len;
        int ab_at;
        logic [1:0]  m;
        logic [15:0] s;
        bus.start = 0; bus.abort = 0; bus.mode = 0; bus.seed = 0;
        bus.step = 0; bus.length = 0; bus.buffer_full = 0;

        tick(); tick();
        check("rst_en", bus.data_1_en, 1'b0);
        check("rst_data", bus.data_1, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_cnt", bus.sent_count, 8'd0);
        rst = 1'b0;
        tick();

        run_burst("inc", 2'b00, 16'h0010, 16'd2, 4, 0, -1, -1, 0, acc);
        check_idle_after("inc", 8'd4);
        run_burst("wrap", 2'b00, 16'hFFFE, 16'd1, 3, 0, -1, -1, 0, acc);
        check_idle_after("wrap", 8'd3);
        run_burst("stall", 2'b00, 16'h1234, 16'h0101, 5, 0, -1, 1, 3, acc);
        check_idle_after("stall", 8'd5);
        run_burst("lfsr", 2'b10, 16'h0000, 16'd0, 3, 0, -1, -1, 0, acc);
        check_idle_after("lfsr", 8'd3);
        run_burst("len0", 2'b00, 16'h5555, 16'd1, 0, 0, -1, -1, 0, acc);
        check_idle_after("len0", 8'd0);

        run_burst("abort", 2'b01, 16'hBEEF, 16'd7, 10, 0, 3, 3, 1, acc);
        bus.start  = 1'b1;
        bus.length = 8'd5;
        tick();
        bus.start = 1'b0;
        check("start_in_done_busy", bus.busy, 1'b0);
        check("start_in_done_en", bus.data_1_en, 1'b0);
        check("start_in_done_done", bus.done, 1'b0);
        check("start_in_done_cnt", bus.sent_count, 8'd3);
        tick();
        check("start_in_done_stay_idle", bus.data_1_en, 1'b0);

        bus.start = 1'b1; bus.mode = 2'b01; bus.seed = 16'hBEEF; bus.length = 8'd10;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("rerun_running", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_en", bus.data_1_en, 1'b0);
        check("midrst_data", bus.data_1, 16'h0000);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_cnt", bus.sent_count, 8'd0);
        rst = 1'b0;
        tick();
        check("midrst_no_words", bus.data_1_en, 1'b0);

        for (int i = 0; i < 14; i++) begin
            m     = 2'($urandom_range(3));
            s     = ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom);
            len   = $urandom_range(12);
            ab_at = ($urandom_range(2) == 0) ? $urandom_range(len) : -1;
            run_burst("rand", m, s, 16'($urandom), len, 30, ab_at, -1, 0, acc);
            check_idle_after("rand", LW'(acc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wrapper_source.md
Name: wrapper_source

Overview:
Single-clock stream producer on the write side of the dual-clock word buffer. On command it generates a sequence of 16-bit words: incrementing, constant or LFSR. It presents each word on data_1 with data_1_en and obeys buffer_full backpressure. It reports progress with busy, done and sent_count, and sits in the clk_1 domain next to the buffer.

Parameters:
DATA_W, 16, word width (LFSR taps defined for 16 only)
LEN_W, 8, width of length and sent_count

Ports:
clk_1  input  1  sole clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle command strobe, honoured only in IDLE
abort  input  1  stop current burst, honoured only in RUN
mode  input  2  00 incrementing, 01 constant, 10 LFSR, 11 reserved (treated as 01)
seed  input  DATA_W  first word of the burst
step  input  DATA_W  increment for mode 00
length  input  LEN_W  number of words in the burst (0 allowed)
buffer_full  input  1  backpressure from the buffer
data_1_en  output  1  word valid toward the buffer
data_1  output  DATA_W  word toward the buffer
busy  output  1  high in RUN
done  output  1  one-cycle pulse at burst end or abort
sent_count  output  LEN_W  words accepted in the current or last burst

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk_1, rst).
- Reset: state IDLE; data_1_en=0, data_1=0, busy=0, done=0, sent_count=0, internal regs 0.
- Reset mid-burst: all outputs return to reset values on the next edge, with no further words driven.
- Transfer rule: a word is accepted on a clk_1 edge where data_1_en=1 and buffer_full=0.
  - While data_1_en=1 and buffer_full=1, data_1 and data_1_en hold stable.
  - data_1_en never drops before acceptance, except on abort or rst.
- States:
  - IDLE -> RUN: start=1 and length!=0.
  - IDLE -> DONE: start=1 and length==0.
  - RUN -> DONE: acceptance of word number length, or abort=1.
  - DONE -> IDLE: unconditionally, after one cycle.
- On start in IDLE (edge N):
  - length, mode and step are latched.
  - sent_count is cleared.
  - From edge N, data_1=seed (LFSR: seed==0 replaced by 16'hACE1).
  - data_1_en=1 and busy=1 when length!=0.
  - Inputs changing after the start edge do not affect the running burst.
- Next-word generation, applied on each acceptance edge:
  - Mode 00: data_1 <= data_1 + step, mod 2^16 wrap.
  - Mode 01: data_1 unchanged.
  - Mode 10: Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Shift left; new bit0 = b15^b13^b12^b10.
- sent_count increments by 1 on each acceptance edge.
  - Final value equals length for a completed burst, or the accepted count on abort.
  - It holds until the next honoured start.
- Last acceptance edge:
  - Enters DONE; data_1_en=0 and busy=0.
  - done=1 for exactly the DONE cycle.
  - data_1 keeps its last generated value.
- Abort in RUN, with or without buffer_full:
  - A word accepted on the same edge counts (abort and acceptance coincide).
  - Next cycle: DONE, data_1_en=0, done=1.
- start while busy or in DONE: ignored. abort outside RUN: ignored.
- Latency: first word valid 1 cycle after the start edge. With buffer_full=0 throughout, N words take N cycles and done follows on the cycle after the last word.

Test Plan:
- rst, then start with mode=00, seed=16'h0010, step=2, length=4, buffer_full=0 -> data_1 = 0010, 0012, 0014, 0016 on consecutive cycles with data_1_en=1; done pulse next cycle; sent_count=4; busy=0.
- Mode 00, seed=16'hFFFE, step=1, length=3 -> FFFE, FFFF, 0000 (wrap); sent_count=3.
- Mode 00, length=5, buffer_full forced high for 3 cycles during word 2 -> word 2 held stable with data_1_en=1 for 3 extra cycles; total 5 distinct accepted words; done only after the 5th.
- Mode 10, seed=0, length=3 -> ACE1, 59C3, B387; done pulse.
- Start with length=0 -> data_1_en never asserted; done=1 exactly one cycle later; sent_count=0.
- Mode 01, seed=16'hBEEF, length=10:
  - abort on the cycle after the 3rd acceptance -> data_1_en=0 next cycle; done pulse; sent_count=3.
  - Then start during DONE -> ignored.
  - rst asserted mid-burst in a rerun -> all outputs 0 on the next edge.
